// File: rtl/vx_tcu_step_issuer.sv
// vx_tcu_step_issuer
//   Issue-side sequencer for the tensor core unit. Takes one tile command
//   (header, three operand blocks, M/N step counts minus one) and expands it
//   into (m_steps+1)*(n_steps+1) execute beats. step_n is the fastest-changing
//   index. A credit counter bounds the number of outstanding beats.
//
//   Optional feature macro: TCU_ISSUE_PERF_EN adds perf_stall_cycles, a 32-bit
//   count of ISSUE cycles in which no beat could be offered (credit stall).
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_header, cmd_m_steps, cmd_n_steps, cmd_rs1/2/3_data   command payload
//   exe_valid/exe_ready        execute beat handshake to the TCU core
//   exe_header, exe_step_m, exe_step_n, exe_rs1/2/3_data, exe_last   beat payload
//   rsp_fire                   TCU result handshake, returns one credit
//   busy                       not idle or beats outstanding
//   inflight                   outstanding beat count
//   perf_stall_cycles          (TCU_ISSUE_PERF_EN only) credit-stall cycles
//
// States
//   S_IDLE  | waiting for a command, cmd_ready high
//   S_ISSUE | walking the M/N steps, offering beats while credits remain

module vx_tcu_step_issuer #(
  parameter int HEADER_W     = 64,
  parameter int DATA_W       = 512,
  parameter int MAX_INFLIGHT = 8,
  parameter int STEP_W       = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [HEADER_W-1:0]                   cmd_header,
  input  logic [STEP_W-1:0]                     cmd_m_steps,
  input  logic [STEP_W-1:0]                     cmd_n_steps,
  input  logic [DATA_W-1:0]                     cmd_rs1_data,
  input  logic [DATA_W-1:0]                     cmd_rs2_data,
  input  logic [DATA_W-1:0]                     cmd_rs3_data,
  output logic                                  exe_valid,
  input  logic                                  exe_ready,
  output logic [HEADER_W-1:0]                   exe_header,
  output logic [STEP_W-1:0]                     exe_step_m,
  output logic [STEP_W-1:0]                     exe_step_n,
  output logic [DATA_W-1:0]                     exe_rs1_data,
  output logic [DATA_W-1:0]                     exe_rs2_data,
  output logic [DATA_W-1:0]                     exe_rs3_data,
  output logic                                  exe_last,
  input  logic                                  rsp_fire,
  output logic                                  busy,
`ifdef TCU_ISSUE_PERF_EN
  output logic [31:0]                           perf_stall_cycles,
`else
  // perf_stall_cycles port not present in this build
`endif
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [STEP_W-1:0]    step_m_q, step_m_d;
  logic [STEP_W-1:0]    step_n_q, step_n_d;
  logic [STEP_W-1:0]    m_steps_q, m_steps_d;
  logic [STEP_W-1:0]    n_steps_q, n_steps_d;
  logic [HEADER_W-1:0]  header_q, header_d;
  logic [DATA_W-1:0]    rs1_q, rs1_d;
  logic [DATA_W-1:0]    rs2_q, rs2_d;
  logic [DATA_W-1:0]    rs3_q, rs3_d;
  logic [CNT_W-1:0]     inflight_q, inflight_d;

  logic exe_fire;
  logic rsp_take;
  logic is_last;

  always_comb begin
    state_d    = state_q;
    step_m_d   = step_m_q;
    step_n_d   = step_n_q;
    m_steps_d  = m_steps_q;
    n_steps_d  = n_steps_q;
    header_d   = header_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rs3_d      = rs3_q;
    cmd_ready  = 1'b0;
    exe_valid  = 1'b0;
    exe_last   = 1'b0;
    exe_fire   = 1'b0;
    is_last    = (step_m_q == m_steps_q) && (step_n_q == n_steps_q);

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          header_d  = cmd_header;
          rs1_d     = cmd_rs1_data;
          rs2_d     = cmd_rs2_data;
          rs3_d     = cmd_rs3_data;
          m_steps_d = cmd_m_steps;
          n_steps_d = cmd_n_steps;
          step_m_d  = '0;
          step_n_d  = '0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Credits only shrink through our own fires, so once exe_valid is
        // high it stays high until that beat fires.
        exe_valid = (inflight_q < MAX_CNT);
        exe_last  = is_last;
        exe_fire  = exe_valid && exe_ready;
        if (exe_fire) begin
          if (is_last) begin
            // Park the indices at zero so IDLE shows the reset values.
            step_m_d = '0;
            step_n_d = '0;
            state_d  = S_IDLE;
          end else if (step_n_q == n_steps_q) begin
            step_n_d = '0;
            step_m_d = step_m_q + 1'b1;
          end else begin
            step_n_d = step_n_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A stray response at zero credits is ignored so the counter cannot wrap.
  assign rsp_take = rsp_fire && (inflight_q != '0);

  always_comb begin
    inflight_d = inflight_q;
    case ({exe_fire, rsp_take})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      step_m_q   <= '0;
      step_n_q   <= '0;
      m_steps_q  <= '0;
      n_steps_q  <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      step_m_q   <= step_m_d;
      step_n_q   <= step_n_d;
      m_steps_q  <= m_steps_d;
      n_steps_q  <= n_steps_d;
      inflight_q <= inflight_d;
    end
  end

  // Payload registers are only meaningful after a command is accepted.
  always_ff @(posedge clk) begin
    header_q <= header_d;
    rs1_q    <= rs1_d;
    rs2_q    <= rs2_d;
    rs3_q    <= rs3_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(rsp_fire && (inflight_q == '0)));
    end
  end

`ifdef TCU_ISSUE_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q + {31'd0, (state_q == S_ISSUE) && !exe_valid};
  end

  always_ff @(posedge clk) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_stall_cycles = perf_q;
`else
  // No stall counter in this build.
`endif

  assign exe_header   = header_q;
  assign exe_rs1_data = rs1_q;
  assign exe_rs2_data = rs2_q;
  assign exe_rs3_data = rs3_q;
  assign exe_step_m   = step_m_q;
  assign exe_step_n   = step_n_q;
  assign busy         = (state_q != S_IDLE) || (inflight_q != '0);
  assign inflight     = inflight_q;

endmodule

// File: tb/tb_vx_tcu_step_issuer.sv
module tb_vx_tcu_step_issuer;

  localparam int HW = 64;
  localparam int DW = 64;
  localparam int MI = 4;
  localparam int SW = 4;
  localparam int CW = $clog2(MI + 1);

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [HW-1:0] cmd_header;
  logic [SW-1:0] cmd_m_steps;
  logic [SW-1:0] cmd_n_steps;
  logic [DW-1:0] cmd_rs1_data, cmd_rs2_data, cmd_rs3_data;
  logic          exe_valid;
  logic          exe_ready;
  logic [HW-1:0] exe_header;
  logic [SW-1:0] exe_step_m, exe_step_n;
  logic [DW-1:0] exe_rs1_data, exe_rs2_data, exe_rs3_data;
  logic          exe_last;
  logic          rsp_fire;
  logic          busy;
  logic [CW-1:0] inflight;

  int checks   = 0;
  int failures = 0;

  vx_tcu_step_issuer #(
    .HEADER_W     (HW),
    .DATA_W       (DW),
    .MAX_INFLIGHT (MI),
    .STEP_W       (SW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_header   (cmd_header),
    .cmd_m_steps  (cmd_m_steps),
    .cmd_n_steps  (cmd_n_steps),
    .cmd_rs1_data (cmd_rs1_data),
    .cmd_rs2_data (cmd_rs2_data),
    .cmd_rs3_data (cmd_rs3_data),
    .exe_valid    (exe_valid),
    .exe_ready    (exe_ready),
    .exe_header   (exe_header),
    .exe_step_m   (exe_step_m),
    .exe_step_n   (exe_step_n),
    .exe_rs1_data (exe_rs1_data),
    .exe_rs2_data (exe_rs2_data),
    .exe_rs3_data (exe_rs3_data),
    .exe_last     (exe_last),
    .rsp_fire     (rsp_fire),
    .busy         (busy),
    .inflight     (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [HW-1:0] hdr, input int m, input int n);
    cmd_valid    = 1'b1;
    cmd_header   = hdr;
    cmd_m_steps  = SW'(m);
    cmd_n_steps  = SW'(n);
    cmd_rs1_data = hdr + 64'd1;
    cmd_rs2_data = hdr + 64'd2;
    cmd_rs3_data = hdr + 64'd3;
  endtask

  task automatic send_cmd(input logic [HW-1:0] hdr, input int m, input int n);
    set_cmd(hdr, m, n);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] rdy_pat;
    int exp_k;
    int exp_inf;
    int cyc;
    logic fire;
    logic rsp;

    reset = 1'b1; cmd_valid = 1'b0; exe_ready = 1'b0; rsp_fire = 1'b0;
    cmd_header = '0; cmd_m_steps = '0; cmd_n_steps = '0;
    cmd_rs1_data = '0; cmd_rs2_data = '0; cmd_rs3_data = '0;
    repeat (2) tick();
    reset = 1'b0;

    // Reset state
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_exe_valid", exe_valid, 0);
    chk("rst_exe_last", exe_last, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_busy", busy, 0);
    chk("rst_step_m", exe_step_m, 0);
    chk("rst_step_n", exe_step_n, 0);

    // 2x2 command, ready held high, responses afterwards
    exe_ready = 1'b1;
    send_cmd(64'hA1, 1, 1);
    chk("t1_cmd_ready_busy", cmd_ready, 0);
    for (int k = 0; k < 4; k++) begin
      chk("t1_valid", exe_valid, 1);
      chk("t1_step_m", exe_step_m, 64'(k / 2));
      chk("t1_step_n", exe_step_n, 64'(k % 2));
      chk("t1_last", exe_last, (k == 3));
      chk("t1_header", exe_header, 64'hA1);
      chk("t1_rs1", exe_rs1_data, 64'hA2);
      tick();
    end
    chk("t1_cmd_ready_after", cmd_ready, 1);
    chk("t1_valid_after", exe_valid, 0);
    chk("t1_inflight4", inflight, 4);
    chk("t1_busy_inflight", busy, 1);
    for (int k = 0; k < 4; k++) begin
      rsp_fire = 1'b1;
      tick();
      chk("t1_drain", inflight, 64'(3 - k));
    end
    rsp_fire = 1'b0;
    chk("t1_busy_done", busy, 0);

    // 1x8 command, credit stall at MI=4, then same-cycle fire and response
    send_cmd(64'hB1, 0, 7);
    for (int k = 0; k < 4; k++) begin
      chk("t2_valid", exe_valid, 1);
      chk("t2_step_n", exe_step_n, 64'(k));
      tick();
    end
    chk("t2_stall_valid", exe_valid, 0);
    chk("t2_stall_inflight", inflight, 4);
    chk("t2_stall_busy", busy, 1);
    tick(); tick();
    chk("t2_stall_hold", exe_valid, 0);
    chk("t2_stall_step", exe_step_n, 4);
    rsp_fire = 1'b1;
    tick();
    rsp_fire = 1'b0;
    chk("t2_credit_inflight", inflight, 3);
    chk("t2_credit_valid", exe_valid, 1);
    chk("t2_credit_step", exe_step_n, 4);
    tick();
    chk("t2_refire_inflight", inflight, 4);
    chk("t2_refire_valid", exe_valid, 0);
    chk("t2_refire_step", exe_step_n, 5);
    rsp_fire = 1'b1;
    tick();
    chk("t2_rsp_only", inflight, 3);
    tick();
    chk("t2_both_inflight", inflight, 3);
    chk("t2_both_step", exe_step_n, 6);
    tick();
    chk("t2_both2_inflight", inflight, 3);
    chk("t2_last_step", exe_step_n, 7);
    chk("t2_last", exe_last, 1);
    tick();
    chk("t2_end_inflight", inflight, 3);
    chk("t2_end_valid", exe_valid, 0);
    chk("t2_end_cmd_ready", cmd_ready, 1);
    tick(); tick(); tick();
    rsp_fire = 1'b0;
    chk("t2_drained", inflight, 0);

    // 2x4 command with exe_ready toggling; responses follow one cycle behind
    rdy_pat = 32'hB6D3_5A9D;
    send_cmd(64'hC1, 1, 3);
    exp_k = 0; exp_inf = 0; cyc = 0;
    while (exp_k < 8 && cyc < 32) begin
      exe_ready = rdy_pat[cyc];
      rsp = (exp_inf > 0);
      rsp_fire = rsp;
      chk("t3_valid", exe_valid, (exp_inf < MI));
      chk("t3_step_m", exe_step_m, 64'(exp_k / 4));
      chk("t3_step_n", exe_step_n, 64'(exp_k % 4));
      chk("t3_last", exe_last, (exp_k == 7));
      chk("t3_header", exe_header, 64'hC1);
      chk("t3_rs2", exe_rs2_data, 64'hC3);
      fire = exe_ready && (exp_inf < MI);
      tick();
      exp_inf = exp_inf + (fire ? 1 : 0) - (rsp ? 1 : 0);
      exp_k = exp_k + (fire ? 1 : 0);
      chk("t3_inflight", inflight, 64'(exp_inf));
      cyc++;
    end
    chk("t3_beats", 64'(exp_k), 8);
    chk("t3_idle", cmd_ready, 1);
    rsp_fire = (exp_inf > 0);
    tick();
    rsp_fire = 1'b0;
    exe_ready = 1'b1;
    chk("t3_drained", inflight, 0);

    // Reset in the middle of a 6-beat command
    send_cmd(64'hD1, 1, 2);
    tick(); tick();
    chk("t4_pre_inflight", inflight, 2);
    chk("t4_pre_step_n", exe_step_n, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_cmd_ready", cmd_ready, 1);
    chk("t4_valid", exe_valid, 0);
    chk("t4_inflight", inflight, 0);
    chk("t4_busy", busy, 0);
    chk("t4_step_m", exe_step_m, 0);
    chk("t4_step_n", exe_step_n, 0);
    send_cmd(64'hE1, 0, 0);
    chk("t4_new_valid", exe_valid, 1);
    chk("t4_new_step_m", exe_step_m, 0);
    chk("t4_new_step_n", exe_step_n, 0);
    chk("t4_new_last", exe_last, 1);
    chk("t4_new_header", exe_header, 64'hE1);
    tick();
    chk("t4_new_inflight", inflight, 1);
    chk("t4_new_idle", cmd_ready, 1);
    rsp_fire = 1'b1;
    tick();
    rsp_fire = 1'b0;
    chk("t4_drained", inflight, 0);

    // Back-to-back: 1 beat, then 1x2 beats, cmd_valid held
    set_cmd(64'hF1, 0, 0);
    tick();
    set_cmd(64'hF2, 0, 1);
    chk("t5_a_cmd_ready", cmd_ready, 0);
    chk("t5_a_valid", exe_valid, 1);
    chk("t5_a_last", exe_last, 1);
    chk("t5_a_header", exe_header, 64'hF1);
    tick();
    chk("t5_gap_cmd_ready", cmd_ready, 1);
    chk("t5_gap_valid", exe_valid, 0);
    chk("t5_gap_inflight", inflight, 1);
    tick();
    cmd_valid = 1'b0;
    chk("t5_b_valid", exe_valid, 1);
    chk("t5_b_header", exe_header, 64'hF2);
    chk("t5_b_rs3", exe_rs3_data, 64'hF5);
    chk("t5_b_step_n0", exe_step_n, 0);
    chk("t5_b_last0", exe_last, 0);
    chk("t5_b_inflight1", inflight, 1);
    tick();
    chk("t5_b_inflight2", inflight, 2);
    chk("t5_b_step_n1", exe_step_n, 1);
    chk("t5_b_last1", exe_last, 1);
    tick();
    chk("t5_end_inflight", inflight, 3);
    chk("t5_end_cmd_ready", cmd_ready, 1);
    chk("t5_end_valid", exe_valid, 0);
    for (int k = 0; k < 3; k++) begin
      rsp_fire = 1'b1;
      tick();
      chk("t5_drain", inflight, 64'(2 - k));
    end
    rsp_fire = 1'b0;
    chk("t5_busy_done", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
